mux_pipe_skid: RTL
==================

Name: mux_pipe_skid

Overview:
- Parametrised N:1 WIDTH-bit select mux with a registered, back-pressure-tolerant output stage.
- The output stage is a 2-entry skid buffer with a valid/ready handshake on both sides.
- Used for operand and forwarding selection between pipeline stages, where the downstream stage may stall.
- Out-of-range selects resolve to the highest-numbered input and raise a flag that travels with the data.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 3, number of inputs; legal range 2..16.
- SEL_W, 2, select width; must equal clog2(NUM_IN); an elaboration-time check fails if it does not.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_flat  in  NUM_IN*WIDTH  concatenated inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  input select, sampled with in_valid.
- in_valid  in  1  upstream offers in_flat/sel this cycle.
- in_ready  out  1  block can accept this cycle; driven directly from a register.
- flush  in  1  synchronous pipeline flush.
- out_data  out  WIDTH  selected data at the head of the buffer.
- out_sel_err  out  1  head entry was captured with sel >= NUM_IN.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry this cycle.

Behaviour:
- Selection (combinational, before capture): if sel < NUM_IN, pick input[sel]; otherwise pick input[NUM_IN-1] and set err=1.
- Storage: main entry (M) drives the outputs; skid entry (S) holds overflow. Each entry holds {data, err, valid}.
- Transfers: accept = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = ~S.valid. It depends only on registered state and has no combinational path from out_ready.
- Latency: data accepted at edge t appears on out_data after edge t, i.e. one cycle, when M is empty or popping in the same cycle.
- Throughput: one transfer per cycle with out_ready held high.
- Next-state rules, applied at each edge in priority order:
  - rst_n low (asynchronous): M.valid=0, S.valid=0, M.data=0, M.err=0, S contents=0.
  - flush=1: M.valid=0, S.valid=0. Any accept in the same cycle is dropped, and so is any pop. in_ready=1 next cycle.
  - M empty, accept: M <= new entry.
  - M full, pop, S empty, accept: M <= new entry.
  - M full, pop, S empty, no accept: M.valid <= 0.
  - M full, pop, S full: M <= S, S.valid <= 0. No accept is possible because in_ready=0.
  - M full, no pop, accept: S <= new entry.
  - M full, no pop, no accept: hold.
- Reset output values: out_valid=0, out_data=0, out_sel_err=0, in_ready=1.
- Reset released mid-stream: the first accept after release lands in M, with no spurious out_valid beforehand.
- Ordering: strict FIFO; data is never duplicated and never lost unless flushed.
- Stability: while out_valid=1 and out_ready=0, out_data and out_sel_err hold constant.
- out_data while out_valid=0: holds the last value and is don't-care for checkers.

Test Plan:
1. Reset then streaming: NUM_IN=3, in_flat={C,B,A} with A=0x11111111, B=0x22222222, C=0x33333333, sel=0,1,2 on consecutive cycles, out_ready=1 -> out_data=0x11111111, 0x22222222, 0x33333333 one cycle later each; out_valid continuous; out_sel_err=0 throughout.
2. Out-of-range select: sel=3 with the same inputs -> out_data=0x33333333, out_sel_err=1; the next beat with sel=1 -> 0x22222222, out_sel_err=0.
3. Back-pressure/skid: stream 4 beats with values 1,2,3,4; drop out_ready after beat 1 is captured -> beat 2 lands in S and in_ready=0 on the following cycle. Raise out_ready -> outputs 1,2,3,4 in order, none lost or duplicated; in_ready returns to 1 one cycle after S drains.
4. Flush with both entries full, in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and the flushed and concurrent beats never appear.
5. Asynchronous reset: assert rst_n=0 mid-cycle while M holds 0xDEADBEEF with out_ready=0 -> out_valid=0 and out_data=0 immediately, without waiting for a clock edge. After release, the first accepted beat 0x5 appears with out_valid=1 one cycle later.
6. Random soak, WIDTH=8, NUM_IN=5: random in_valid, out_ready, sel, flush -> scoreboard matches data and err in order; out_data stable whenever out_valid=1 and out_ready=0; no path from out_ready to in_ready within a cycle.

Source files
------------

// File: rtl/mux_pipe_skid.sv
// mux_pipe_skid: N:1 select mux feeding a 2-entry skid buffer with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_flat             NUM_IN concatenated inputs, input k at [k*WIDTH +: WIDTH]
//   sel                 input select, sampled together with in_valid
//   in_valid, in_ready  upstream handshake (in_ready comes straight from a flop)
//   flush               synchronous flush of both buffer entries
//   out_data            data of the head entry
//   out_sel_err         head entry was captured with sel >= NUM_IN
//   out_valid, out_ready downstream handshake
module mux_pipe_skid #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_IN*WIDTH-1:0]  in_flat,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int unsigned LAST_IN = NUM_IN - 1;

  // Elaboration-time parameter sanity checks
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
    $error("mux_pipe_skid: NUM_IN=%0d outside legal range 2..16", NUM_IN);
  end
  if (SEL_W != $clog2(NUM_IN)) begin : g_bad_sel_w
    $error("mux_pipe_skid: SEL_W=%0d must equal clog2(NUM_IN)=%0d", SEL_W, $clog2(NUM_IN));
  end

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } entry_t;

  // EMPTY: nothing held; ONE: main entry only; TWO: main and skid entries
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;

  logic [WIDTH-1:0] in_arr [NUM_IN];
  logic             sel_ok_c;
  logic [SEL_W-1:0] sel_idx_c;
  entry_t           new_c;
  logic             accept_c;
  logic             pop_c;

  // Split the flat input bus into an indexable array
  for (genvar k = 0; k < NUM_IN; k++) begin : g_split
    assign in_arr[k] = in_flat[k*WIDTH +: WIDTH];
  end

  // Out-of-range selects clamp to the last input and are flagged
  always_comb begin
    sel_ok_c   = (32'(sel) < NUM_IN);
    sel_idx_c  = sel_ok_c ? sel : SEL_W'(LAST_IN);
    new_c.data = in_arr[sel_idx_c];
    new_c.err  = ~sel_ok_c;
  end

  assign accept_c = in_valid & in_ready_q;
  assign pop_c    = out_valid_q & out_ready;

  // Occupancy state register and buffer storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state and next-output logic; flush overrides any accept or pop
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            m_d     = new_c;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop_c) begin
            if (accept_c) m_d = new_c;
            else          state_d = ST_EMPTY;
          end else if (accept_c) begin
            s_d     = new_c;
            state_d = ST_TWO;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a pop can change anything
          if (pop_c) begin
            m_d     = s_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  assign out_data    = m_q.data;
  assign out_sel_err = m_q.err;
  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;

endmodule
